// File: rtl/pulse_event_batcher_pkg.sv
// Shared state type and default parameter values for the pulse event batcher.
package pulse_batch_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, SEND} batch_state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_THRESH  = 16;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_TMR_W   = 8;

endpackage

// File: rtl/pulse_event_batcher_sat_acc.sv
// Saturating event accumulator: counts one per inc, sticks at all-ones and
// flags any increment that could not be absorbed.
module sat_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] acc_next,
    output logic             drop
);

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    logic [CNT_W-1:0] acc_reg;

    always_comb begin
        drop     = inc && (acc_reg == ACC_MAX);
        acc_next = (inc && !drop) ? acc_reg + CNT_W'(1) : acc_reg;
    end

    // clr wins so a closing batch starts the next one from zero
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/pulse_event_batcher.sv
// Groups synchronized event pulses into batches closed by count threshold or
// by a timeout after the first pulse, presented on a valid/ready interface.
module pulse_event_batcher
    import pulse_batch_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int THRESH  = DEF_THRESH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMR_W   = DEF_TMR_W
) (
    input  logic             clkb,
    input  logic             rstb,
    input  logic             pulse_in,
    input  logic             ovf_clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] THRESH_V     = CNT_W'(THRESH);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);

    batch_state_t     state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             overflow_reg;

    logic [CNT_W-1:0] acc_next;
    logic             drop;
    logic             batch_close;

    // A batch closes on the cycle its count (including this cycle's pulse)
    // reaches the threshold, or when the partial batch has aged out.
    always_comb begin
        batch_close = 1'b0;
        case (state_reg)
            IDLE:    batch_close = pulse_in && (acc_next >= THRESH_V);
            ACCUM:   batch_close = (acc_next >= THRESH_V) || (timer_reg == TIMEOUT_LAST);
            default: batch_close = 1'b0;
        endcase
    end

    sat_acc #(
        .CNT_W(CNT_W)
    ) u_sat_acc (
        .clk     (clkb),
        .srst    (rstb),
        .inc     (pulse_in),
        .clr     (batch_close),
        .acc_next(acc_next),
        .drop    (drop)
    );

    always_ff @(posedge clkb) begin
        if (rstb) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pulse_in) begin
                        timer_reg <= '0;
                        if (batch_close) begin
                            state_reg     <= SEND;
                            out_count_reg <= acc_next;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (batch_close) begin
                        state_reg     <= SEND;
                        out_count_reg <= acc_next;
                        out_valid_reg <= 1'b1;
                        timer_reg     <= '0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                SEND: begin
                    // pulses seen here already live in the accumulator
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        timer_reg     <= '0;
                        state_reg     <= (acc_next != '0) ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_event_batcher.sv
// Scoreboard bench for pulse_event_batcher: directed scenarios plus random
// traffic, checked against a count/age model of batch formation.
module tb_pulse_event_batcher;

    localparam int CNT_W   = 8;
    localparam int THRESH  = 16;
    localparam int TIMEOUT = 255;
    localparam int TMR_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clkb = 1'b0;
    logic             rstb = 1'b1;
    logic             pulse_in = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic             overflow;
    logic             busy;

    always #5 clkb = ~clkb;

    pulse_event_batcher #(
        .CNT_W  (CNT_W),
        .THRESH (THRESH),
        .TIMEOUT(TIMEOUT),
        .TMR_W  (TMR_W)
    ) dut (
        .clkb     (clkb),
        .rstb     (rstb),
        .pulse_in (pulse_in),
        .ovf_clr  (ovf_clr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_count(out_count),
        .overflow (overflow),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Model: events gathered for the batch under construction, its age,
    // whether a finished batch is on display, and the sticky loss flag.
    bit m_open = 0;
    bit m_show = 0;
    bit m_ovf  = 0;
    int m_cnt  = 0;
    int m_age  = 0;
    int m_out  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_step(bit p, bit r, bit c, bit rst);
        bit lost;
        lost = 0;
        if (rst) begin
            m_open = 0; m_show = 0; m_ovf = 0;
            m_cnt = 0; m_age = 0; m_out = 0;
            exp_q.delete();
            return;
        end
        if (m_show) begin
            if (p) begin
                if (m_cnt == MAXC) lost = 1;
                else m_cnt++;
            end
            if (r) begin
                m_show = 0;
                if (m_cnt > 0) begin
                    m_open = 1;
                    m_age  = 0;
                end
            end
        end else begin
            if (p && m_cnt < MAXC) m_cnt++;
            if (m_open || m_cnt > 0) begin
                if (m_cnt >= THRESH || (m_open && m_age == TIMEOUT - 1)) begin
                    exp_q.push_back(m_cnt);
                    m_out  = m_cnt;
                    m_show = 1;
                    m_open = 0;
                    m_cnt  = 0;
                end else if (!m_open) begin
                    m_open = 1;
                    m_age  = 0;
                end else begin
                    m_age++;
                end
            end
        end
        if (lost) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic cyc(bit p, bit r, bit c, bit rst);
        pulse_in  = p;
        out_ready = r;
        ovf_clr   = c;
        rstb      = rst;
        @(posedge clkb);
        model_step(p, r, c, rst);
        @(negedge clkb);
    endtask

    // Monitor: per-cycle output checks plus batch pop on each new presentation.
    bit prev_valid = 0;
    always @(negedge clkb) begin
        check("out_valid", out_valid, m_show);
        check("busy", busy, m_open || m_show);
        check("overflow", overflow, m_ovf);
        check("out_count", out_count, m_out);
        if (out_valid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL batch_unexpected actual=%0d required=none", out_count);
            end else begin
                check("batch_count", out_count, exp_q.pop_front());
            end
        end
        prev_valid = (out_valid === 1'b1);
    end

    task automatic fill_and_saturate();
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 260; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        int dens, rdy;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        check("reset_valid", out_valid, 0);
        check("reset_count", out_count, 0);

        // threshold batch and return to idle
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0);
        check("t1_valid", out_valid, 1);
        check("t1_count", out_count, 16);
        cyc(0, 1, 0, 0);
        check("t1_idle", busy, 0);

        // timeout batch of three sparse pulses
        for (int i = 0; i < 256; i++) cyc(i == 0 || i == 5 || i == 9, 1, 0, 0);
        check("t2_valid", out_valid, 1);
        check("t2_count", out_count, 3);
        cyc(0, 1, 0, 0);
        check("t2_single", out_valid, 0);

        // hold under backpressure, saturation, overflow clear priority
        fill_and_saturate();
        check("t3_hold", out_count, 16);
        check("t3_ovf", overflow, 1);
        cyc(1, 0, 1, 0);
        check("t6_set_wins", overflow, 1);
        cyc(0, 0, 1, 0);
        check("t6_clear", overflow, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("t3_valid", out_valid, 1);
        check("t3_count", out_count, 255);
        cyc(0, 1, 0, 0);

        // reset while presenting with overflow set
        fill_and_saturate();
        check("t5_pre_ovf", overflow, 1);
        cyc(0, 0, 0, 1);
        check("t5_valid", out_valid, 0);
        check("t5_count", out_count, 0);
        check("t5_ovf", overflow, 0);
        check("t5_busy", busy, 0);

        // pulse in the handshake cycle becomes a timeout batch of one
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 255; i++) cyc(0, 1, 0, 0);
        check("t4_valid", out_valid, 1);
        check("t4_count", out_count, 1);
        cyc(0, 1, 0, 0);

        // random traffic in segments of varying density and backpressure
        for (int s = 0; s < 10; s++) begin
            dens = $urandom_range(100);
            rdy  = (s % 3 == 0) ? 0 : $urandom_range(100);
            for (int i = 0; i < 400; i++) begin
                cyc($urandom_range(99) < dens, $urandom_range(99) < rdy,
                    $urandom_range(49) == 0, $urandom_range(999) == 0);
            end
        end

        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
